opfetch_sequencer: RTL and testbench

OPFETCH_SEQUENCER -- requirements
Module: opfetch_sequencer

---
 rtl/opfetch_sequencer.sv | 127 ++++++++++++
 tb/tb_opfetch_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opfetch_sequencer.sv
// opfetch_sequencer
//   Opcode fetch / execute sequencer. After reset it requests an opcode from
//   the bus unit, latches it onto Source, then enables the decoder while the
//   execution step counter XPT advances once per completed machine cycle.
//   Decoder requests (finish instruction, restart XPT, hold XPT) are honoured
//   only on the cycle_done strobe.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   mem_rdata[7:0]      opcode byte from the bus unit
//   mem_valid           mem_rdata valid (captured only while fetch_req=1)
//   cycle_done          end-of-machine-cycle strobe
//   PR_Reset_XPT        restart XPT at 0
//   P2_Set_CM1          instruction complete, fetch the next opcode
//   Pa_Ophd             hold XPT for this machine cycle
//   fetch_req           opcode fetch request (state FETCH)
//   enable              decoder enable (state EXEC)
//   XPT/notXPT[4:0]     execution step counter and complement
//   Source/notSource    latched opcode and complement
//   xpt_ovf             sticky: an increment was attempted at XPT=31
//   op_count[15:0]      opcodes fetched since reset (wraps)

module opfetch_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_valid,
    input  logic        cycle_done,
    input  logic        PR_Reset_XPT,
    input  logic        P2_Set_CM1,
    input  logic        Pa_Ophd,
    output logic        fetch_req,
    output logic        enable,
    output logic [4:0]  XPT,
    output logic [4:0]  notXPT,
    output logic [7:0]  Source,
    output logic [7:0]  notSource,
    output logic        xpt_ovf,
    output logic [15:0] op_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  xpt_q, xpt_d;
    logic [7:0]  source_q, source_d;
    logic [15:0] op_count_q, op_count_d;
    logic        ovf_q, ovf_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            xpt_q      <= '0;
            source_q   <= '0;
            op_count_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            xpt_q      <= xpt_d;
            source_q   <= source_d;
            op_count_q <= op_count_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        xpt_d      = xpt_q;
        source_d   = source_q;
        op_count_d = op_count_q;
        ovf_d      = ovf_q;
        fetch_req  = 1'b0;
        enable     = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end

            FETCH: begin
                fetch_req = 1'b1;
                if (mem_valid) begin
                    source_d   = mem_rdata;
                    xpt_d      = '0;
                    op_count_d = op_count_q + 16'd1;
                    state_d    = EXEC;
                end
            end

            EXEC: begin
                enable = 1'b1;
                // Decoder requests are evaluated only at the end of a machine
                // cycle; finishing the instruction outranks everything else.
                if (cycle_done) begin
                    if (P2_Set_CM1) begin
                        state_d = FETCH;
                    end else if (PR_Reset_XPT) begin
                        xpt_d = '0;
                    end else if (Pa_Ophd) begin
                        xpt_d = xpt_q;
                    end else if (xpt_q == 5'd31) begin
                        // Saturate instead of wrapping; remember the attempt.
                        ovf_d = 1'b1;
                    end else begin
                        xpt_d = xpt_q + 5'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign XPT       = xpt_q;
    assign notXPT    = ~xpt_q;
    assign Source    = source_q;
    assign notSource = ~source_q;
    assign xpt_ovf   = ovf_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_opfetch_sequencer.sv
// tb_opfetch_sequencer
//   Self-checking bench for opfetch_sequencer: directed scenarios with fixed
//   expected values, plus randomized traffic compared against a behavioural
//   model of the sequencer's rules.

module tb_opfetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  mem_rdata;
    logic        mem_valid;
    logic        cycle_done;
    logic        PR_Reset_XPT;
    logic        P2_Set_CM1;
    logic        Pa_Ophd;
    logic        fetch_req;
    logic        enable;
    logic [4:0]  XPT;
    logic [4:0]  notXPT;
    logic [7:0]  Source;
    logic [7:0]  notSource;
    logic        xpt_ovf;
    logic [15:0] op_count;

    opfetch_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_rdata    (mem_rdata),
        .mem_valid    (mem_valid),
        .cycle_done   (cycle_done),
        .PR_Reset_XPT (PR_Reset_XPT),
        .P2_Set_CM1   (P2_Set_CM1),
        .Pa_Ophd      (Pa_Ophd),
        .fetch_req    (fetch_req),
        .enable       (enable),
        .XPT          (XPT),
        .notXPT       (notXPT),
        .Source       (Source),
        .notSource    (notSource),
        .xpt_ovf      (xpt_ovf),
        .op_count     (op_count)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Output snapshot: fetch_req, enable, XPT, notXPT, Source, notSource, xpt_ovf, op_count
    logic [44:0] actual;
    assign actual = {fetch_req, enable, XPT, notXPT, Source, notSource, xpt_ovf, op_count};

    localparam logic [44:0] RST_VEC = {1'b0, 1'b0, 5'd0, 5'h1f, 8'h00, 8'hff, 1'b0, 16'h0000};

    // ---------------- behavioural model ----------------
    // phase: 0 = IDLE, 1 = FETCH, 2 = EXEC
    int          m_phase;
    int unsigned m_xpt;
    int unsigned m_src;
    int unsigned m_cnt;
    bit          m_ovf;

    function automatic void model_reset();
        m_phase = 0;
        m_xpt   = 0;
        m_src   = 0;
        m_cnt   = 0;
        m_ovf   = 1'b0;
    endfunction

    function automatic void model_clock();
        if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (mem_valid) begin
                m_src   = mem_rdata;
                m_xpt   = 0;
                m_cnt   = (m_cnt + 1) % 65536;
                m_phase = 2;
            end
        end else if (cycle_done) begin
            if (P2_Set_CM1)        m_phase = 1;
            else if (PR_Reset_XPT) m_xpt = 0;
            else if (Pa_Ophd)      m_xpt = m_xpt;
            else if (m_xpt < 31)   m_xpt = m_xpt + 1;
            else                   m_ovf = 1'b1;
        end
    endfunction

    function automatic logic [44:0] expected();
        logic [4:0]  x;
        logic [7:0]  s;
        logic [15:0] c;
        x = 5'(m_xpt);
        s = 8'(m_src);
        c = 16'(m_cnt);
        return {m_phase == 1, m_phase == 2, x, ~x, s, ~s, m_ovf, c};
    endfunction

    // One clock with the currently driven inputs; sample 1 time unit after the edge.
    task automatic step();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mem_rdata    = 8'h00;
        mem_valid    = 1'b0;
        cycle_done   = 1'b0;
        PR_Reset_XPT = 1'b0;
        P2_Set_CM1   = 1'b0;
        Pa_Ophd      = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        #2;
        n_checks++;
        if (actual !== RST_VEC) begin
            n_fail++;
            $display("FAIL reset_value: got %h, need %h", actual, RST_VEC);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (actual !== RST_VEC) begin
            n_fail++;
            $display("FAIL reset_held: got %h, need %h", actual, RST_VEC);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_first_fetch();
        // mem_valid is already high while still IDLE; it must not capture there.
        mem_valid = 1'b1;
        mem_rdata = 8'hCD;
        n_checks++;
        if (fetch_req !== 1'b0 || enable !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_outputs: fetch_req=%b enable=%b, need 0 0", fetch_req, enable);
        end
        step();
        n_checks++;
        if (fetch_req !== 1'b1 || enable !== 1'b0 || Source !== 8'h00 || op_count !== 16'd0) begin
            n_fail++;
            $display("FAIL first_fetch_req: fetch_req=%b enable=%b Source=%h op_count=%0d, need 1 0 00 0",
                     fetch_req, enable, Source, op_count);
        end
        step();
        n_checks++;
        if (Source !== 8'hCD || notSource !== 8'h32 || enable !== 1'b1 || fetch_req !== 1'b0 ||
            XPT !== 5'd0 || notXPT !== 5'h1f || op_count !== 16'd1) begin
            n_fail++;
            $display("FAIL first_capture: Source=%h notSource=%h enable=%b fetch_req=%b XPT=%0d op_count=%0d, need CD 32 1 0 0 1",
                     Source, notSource, enable, fetch_req, XPT, op_count);
        end
        // mem_valid stays high in EXEC: it must be ignored.
        mem_rdata = 8'hAA;
        step();
        n_checks++;
        if (Source !== 8'hCD || op_count !== 16'd1 || enable !== 1'b1) begin
            n_fail++;
            $display("FAIL single_capture: Source=%h op_count=%0d enable=%b, need CD 1 1", Source, op_count, enable);
        end
        mem_valid = 1'b0;
    endtask

    task automatic test_xpt_count();
        for (int unsigned i = 0; i < 3; i++) begin
            cycle_done = 1'b1;
            step();
            cycle_done = 1'b0;
            for (int unsigned j = 0; j < 2; j++) begin
                step();
                n_checks++;
                if (XPT !== 5'(i + 1) || enable !== 1'b1) begin
                    n_fail++;
                    $display("FAIL xpt_count_idle: XPT=%0d enable=%b, need %0d 1", XPT, enable, i + 1);
                end
            end
        end
        n_checks++;
        if (actual !== expected()) begin
            n_fail++;
            $display("FAIL xpt_count_model: got %h, need %h", actual, expected());
        end
    endtask

    task automatic test_priority();
        cycle_done = 1'b1;
        repeat (2) step();                      // XPT 3 -> 5
        Pa_Ophd = 1'b1;
        step();
        n_checks++;
        if (XPT !== 5'd5) begin
            n_fail++;
            $display("FAIL hold_xpt: XPT=%0d, need 5", XPT);
        end
        PR_Reset_XPT = 1'b1;
        step();
        n_checks++;
        if (XPT !== 5'd0 || notXPT !== 5'h1f || enable !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_over_hold: XPT=%0d notXPT=%h enable=%b, need 0 1f 1", XPT, notXPT, enable);
        end
        Pa_Ophd    = 1'b0;
        P2_Set_CM1 = 1'b1;
        step();
        n_checks++;
        if (fetch_req !== 1'b1 || enable !== 1'b0 || XPT !== 5'd0) begin
            n_fail++;
            $display("FAIL finish_over_reset: fetch_req=%b enable=%b XPT=%0d, need 1 0 0", fetch_req, enable, XPT);
        end
        clear_inputs();
    endtask

    task automatic test_saturate();
        mem_valid = 1'b1;
        mem_rdata = 8'h3C;
        step();
        mem_valid  = 1'b0;
        cycle_done = 1'b1;
        for (int unsigned i = 0; i < 32; i++) begin
            step();
            if (i == 30) begin
                n_checks++;
                if (XPT !== 5'd31 || xpt_ovf !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reach_31: XPT=%0d xpt_ovf=%b, need 31 0", XPT, xpt_ovf);
                end
            end
        end
        n_checks++;
        if (XPT !== 5'd31 || xpt_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL saturate: XPT=%0d xpt_ovf=%b, need 31 1", XPT, xpt_ovf);
        end
        P2_Set_CM1 = 1'b1;
        step();
        clear_inputs();
        mem_valid = 1'b1;
        mem_rdata = 8'h5A;
        step();
        mem_valid = 1'b0;
        n_checks++;
        if (xpt_ovf !== 1'b1 || XPT !== 5'd0 || Source !== 8'h5A || enable !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: xpt_ovf=%b XPT=%0d Source=%h enable=%b, need 1 0 5A 1",
                     xpt_ovf, XPT, Source, enable);
        end
    endtask

    task automatic test_stall_reset();
        cycle_done = 1'b1;
        P2_Set_CM1 = 1'b1;
        step();
        clear_inputs();
        for (int unsigned i = 0; i < 10; i++) begin
            mem_rdata = 8'($urandom);
            step();
            n_checks++;
            if (actual !== expected() || fetch_req !== 1'b1) begin
                n_fail++;
                $display("FAIL fetch_stall: cycle %0d got %h, need %h", i, actual, expected());
            end
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (actual !== RST_VEC) begin
            n_fail++;
            $display("FAIL async_reset_fetch: got %h, need %h", actual, RST_VEC);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        mem_valid = 1'b1;
        mem_rdata = 8'h77;
        step();
        mem_valid = 1'b0;
        n_checks++;
        if (op_count !== 16'd1 || Source !== 8'h77 || xpt_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL capture_after_reset: op_count=%0d Source=%h xpt_ovf=%b, need 1 77 0",
                     op_count, Source, xpt_ovf);
        end
    endtask

    task automatic test_random();
        for (int unsigned i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                model_reset();
                n_checks++;
                if (actual !== RST_VEC) begin
                    n_fail++;
                    $display("FAIL random_reset: iter %0d got %h, need %h", i, actual, RST_VEC);
                end
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            mem_rdata    = 8'($urandom);
            mem_valid    = ($urandom_range(0, 1) == 1);
            cycle_done   = ($urandom_range(0, 1) == 1);
            P2_Set_CM1   = ($urandom_range(0, 7) == 0);
            PR_Reset_XPT = ($urandom_range(0, 7) == 0);
            Pa_Ophd      = ($urandom_range(0, 3) == 0);
            step();
            n_checks++;
            if (actual !== expected()) begin
                n_fail++;
                $display("FAIL random_step: iter %0d got %h, need %h", i, actual, expected());
            end
        end
        clear_inputs();
    endtask

    task automatic test_wrap();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        // Fastest legal loop: capture in FETCH, finish immediately in EXEC.
        mem_valid  = 1'b1;
        mem_rdata  = 8'h96;
        cycle_done = 1'b1;
        P2_Set_CM1 = 1'b1;
        for (int unsigned i = 0; i < 2 * 65535; i++) step();
        n_checks++;
        if (op_count !== 16'hFFFF || fetch_req !== 1'b1) begin
            n_fail++;
            $display("FAIL preload_ffff: op_count=%h fetch_req=%b, need ffff 1", op_count, fetch_req);
        end
        step();
        n_checks++;
        if (op_count !== 16'h0000 || xpt_ovf !== 1'b0 || enable !== 1'b1) begin
            n_fail++;
            $display("FAIL op_count_wrap: op_count=%h xpt_ovf=%b enable=%b, need 0000 0 1",
                     op_count, xpt_ovf, enable);
        end
        n_checks++;
        if (actual !== expected()) begin
            n_fail++;
            $display("FAIL wrap_model: got %h, need %h", actual, expected());
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_xpt_count();
        test_priority();
        test_saturate();
        test_stall_reset();
        test_random();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
